aes_gcm_round_stage: RTL
========================

Name: aes_gcm_round_stage

Overview:
- Generalised AES-GCM encrypt pipeline stage.
- Applies one configurable AES round to the H lane, the J0 lane and NUM_CB_LANES counter-block lanes in parallel.
- Passes plaintext, AAD, instance size, new-instance flag and key schedule through unchanged.
- Adds a valid/ready handshake with a 2-entry skid buffer so a chain of stages can stall without combinational ready paths.

Parameters:
- NUM_CB_LANES, 1, number of parallel counter-block/plaintext lanes (1..8).
- CB_ROUND, 5, AES round index (0..10) applied to every CB lane.
- J0_ROUND, 5, AES round index (0..10) applied to the J0 lane.
- H_ROUND, 7, AES round index (0..10) applied to the H lane.

Ports:
- clk  in  1  stage clock
- rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  upstream beat valid
- o_ready  out  1  stage can accept a beat; registered
- i_h  in  128  H state
- i_encrypted_j0  in  128  J0 state
- i_encrypted_cb  in  128*NUM_CB_LANES  CB states; lane k at bits [128k +: 128]
- i_plain_text  in  128*NUM_CB_LANES  plaintext per lane
- i_aad  in  128  AAD block
- i_instance_size  in  128  instance length field
- i_new_instance  in  1  first beat of new GCM instance
- i_key_schedule  in  1408  11 round keys; key r at bits [128r +: 128]
- o_valid  out  1  downstream beat valid
- i_ready  in  1  downstream accepts
- o_h, o_encrypted_j0  out  128  rounded states
- o_encrypted_cb  out  128*NUM_CB_LANES  rounded CB states
- o_plain_text, o_aad, o_instance_size, o_new_instance, o_key_schedule  out  widths as inputs  passthrough

Behaviour:
- Clocking and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset state:
  - o_valid=0, o_ready=1.
  - Skid entries empty; all data registers cleared to 0.
  - o_new_instance=0.
  - Outputs are deterministic zero-derived values (round function of 0).
- Transfers: input transfer = i_valid & o_ready. Output transfer = o_valid & i_ready.
- Storage: main register M (drives outputs) and skid register S. Each holds the full beat: states, sideband and key schedule.
- Round function (combinational, from M to outputs; fn_aes_encrypt_stage(state, ks, r)):
  - r=0: AddRoundKey(key0) only.
  - r=1..9: SubBytes, ShiftRows, MixColumns, AddRoundKey(key r).
  - r=10: final round, no MixColumns.
  - Each lane uses the key schedule stored with its own beat.
- Latency: 1 cycle from input transfer to o_valid when downstream is not stalling. Throughput: 1 beat/cycle.
- Skid state machine: EMPTY, ONE (M valid), FULL (M and S valid).
  - EMPTY: input transfer -> load M, go to ONE.
  - ONE, in&out: M<=input, stay ONE.
  - ONE, in only: S<=input, go to FULL, o_ready<=0.
  - ONE, out only: go to EMPTY.
  - FULL, out: M<=S, go to ONE, o_ready<=1.
  - FULL, no out: hold everything.
  - o_ready = (state != FULL), registered.
- Data stability: M contents and outputs are stable while o_valid & !i_ready. No beat is ever dropped or duplicated.
- o_new_instance travels with its beat. Beat order is strictly FIFO.
- Reset mid-operation: both entries are discarded immediately and asynchronously. The first beat after reset deassertion is accepted normally.
- Illegal round parameter (>10) or NUM_CB_LANES outside 1..8: elaboration-time $error.

Optional Feature:
- Macro: AES_GCM_STAGE_STATS_EN.
- Defined: adds outputs o_beat_count[31:0] and o_stall_count[31:0].
  - o_beat_count increments on each output transfer.
  - o_stall_count increments each cycle o_valid & !i_ready.
  - Both wrap modulo 2^32 and reset to 0.
- Undefined: the ports and counters are absent. Stage behaviour is otherwise identical.

Decomposition:
- Package aes_pkg holds:
  - AES_BLOCK_W=128, AES_NUM_ROUNDS=10, AES_KS_W=1408.
  - S-box table, xtime/MixColumns helpers.
  - fn_aes_encrypt_stage.
  - A packed struct typedef for the sideband bundle.
- One sub-module: aes_stage_skid_buf, the generic-width 2-entry skid buffer with parameter WIDTH. The stage instantiates it on the concatenated beat.

Test Plan:
- Key 2b7e151628aed2a6abf7158809cf4f3c expanded; CB_ROUND=1; CB=193de3bea0f4e22b9ac68d2ae9f84808 -> o_encrypted_cb=a49c7ff2689f352b6b5bea43026a5049 one cycle later.
- Same key; J0_ROUND=10; J0=eb40f21e592e38848ba113e71bc342d2 -> o_encrypted_j0=3925841d02dc09fbdc118597196a0b32 (no MixColumns).
- NUM_CB_LANES=4; distinct CB/plaintext per lane; i_ready=1 streaming 16 beats -> 16 outputs in order, each lane correct, plaintext lanes unchanged, o_ready constantly 1.
- Hold i_ready=0 for 5 cycles during streaming:
  - o_ready falls the cycle after the second beat is accepted.
  - Outputs remain stable.
  - On release, both beats emerge in order with no loss.
  - With AES_GCM_STAGE_STATS_EN, o_stall_count=5.
- Assert rst_n=0 asynchronously while in FULL -> o_valid=0 and o_ready=1 immediately. The next beat after release has 1-cycle latency.
- i_new_instance=1 on beat 3 of 6 with random i_ready stalls -> o_new_instance=1 only on output beat 3.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES definitions for the GCM round-stage pipeline.
//   AES_BLOCK_W / AES_NUM_ROUNDS / AES_KS_W : block, round-count and key-schedule widths
//   skid_state_e                            : occupancy states of the 2-entry skid buffer
//   aes_sideband_t                          : AAD, instance length and new-instance flag bundle
//   SBOX, fn_xtime, fn_mix_column           : round primitives
//   fn_aes_encrypt_stage(state, ks, r)      : one AES round r (0..10) using key r from ks
// Byte 0 of a 128-bit state is bits [127:120]; byte index = row + 4*column.
package aes_pkg;

  localparam int unsigned AES_BLOCK_W    = 128;
  localparam int unsigned AES_NUM_ROUNDS = 10;
  localparam int unsigned AES_KS_W       = 1408;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

  typedef struct packed {
    logic [AES_BLOCK_W-1:0] aad;
    logic [AES_BLOCK_W-1:0] instance_size;
    logic                   new_instance;
  } aes_sideband_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] fn_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One MixColumns column; c[31:24] is the row-0 byte.
  function automatic logic [31:0] fn_mix_column(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {fn_xtime(a0) ^ fn_xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ fn_xtime(a1) ^ fn_xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ fn_xtime(a2) ^ fn_xtime(a3) ^ a3,
            fn_xtime(a0) ^ a0 ^ a1 ^ a2 ^ fn_xtime(a3)};
  endfunction

  function automatic logic [AES_BLOCK_W-1:0] fn_aes_encrypt_stage(
    input logic [AES_BLOCK_W-1:0] state,
    input logic [AES_KS_W-1:0]    ks,
    input int unsigned            r
  );
    logic [AES_BLOCK_W-1:0] sb, sr, mc, rk, res;
    sb = '0;
    sr = '0;
    mc = '0;
    rk = ks[AES_BLOCK_W*r +: AES_BLOCK_W];
    for (int unsigned i = 0; i < 16; i++) begin
      sb[127-8*i -: 8] = SBOX[state[127-8*i -: 8]];
    end
    // Row `row` rotates left by `row` columns.
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned row = 0; row < 4; row++) begin
        sr[127-8*(4*c+row) -: 8] = sb[127-8*(4*((c+row)%4)+row) -: 8];
      end
    end
    for (int unsigned c = 0; c < 4; c++) begin
      mc[127-32*c -: 32] = fn_mix_column(sr[127-32*c -: 32]);
    end
    if (r == 0)                   res = state ^ rk;
    else if (r == AES_NUM_ROUNDS) res = sr ^ rk;
    else                          res = mc ^ rk;
    return res;
  endfunction

endpackage

// File: rtl/aes_stage_skid_buf.sv
// aes_stage_skid_buf: generic-width 2-entry skid buffer with registered ready.
//   clk, rst_n        : clock, asynchronous active-low reset
//   i_valid, o_ready  : upstream handshake (o_ready is a flop output)
//   i_data [WIDTH]    : upstream beat
//   o_valid, i_ready  : downstream handshake
//   o_data [WIDTH]    : main entry M, stable while stalled
// M always holds the oldest beat; S only fills when M is stalled and a beat
// arrives in the same cycle, so ready can drop one cycle late without loss.
module aes_stage_skid_buf
  import aes_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data
);

  skid_state_e      state_q, state_d;
  logic             ready_q, ready_d;
  logic [WIDTH-1:0] m_q, m_d, s_q, s_d;
  logic             in_xfer, out_xfer;

  assign o_valid  = (state_q != SKID_EMPTY);
  assign o_ready  = ready_q;
  assign o_data   = m_q;
  assign in_xfer  = i_valid & ready_q;
  assign out_xfer = o_valid & i_ready;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    unique case (state_q)
      SKID_EMPTY: begin
        if (in_xfer) begin
          m_d     = i_data;
          state_d = SKID_ONE;
        end
      end
      SKID_ONE: begin
        unique case ({in_xfer, out_xfer})
          2'b11: m_d = i_data;
          2'b10: begin
            s_d     = i_data;
            state_d = SKID_FULL;
          end
          2'b01: state_d = SKID_EMPTY;
          default: ;
        endcase
      end
      SKID_FULL: begin
        if (out_xfer) begin
          m_d     = s_q;
          state_d = SKID_ONE;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
    ready_d = (state_d != SKID_FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SKID_EMPTY;
      ready_q <= 1'b1;
      m_q     <= '0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      m_q     <= m_d;
      s_q     <= s_d;
    end
  end

endmodule

// File: rtl/aes_gcm_round_stage.sv
// aes_gcm_round_stage: one AES-GCM encrypt pipeline stage with skid-buffered handshake.
// Applies round H_ROUND to H, J0_ROUND to J0 and CB_ROUND to each of NUM_CB_LANES
// counter blocks, using the key schedule carried with the beat. Plaintext, AAD,
// instance size, new-instance flag and key schedule pass through unchanged.
//   clk, rst_n                     : clock, asynchronous active-low reset
//   i_valid/o_ready, o_valid/i_ready : upstream / downstream handshakes
//   i_h, i_encrypted_j0, i_encrypted_cb[128*N] : states in;  o_* rounded states out
//   i_plain_text[128*N], i_aad, i_instance_size, i_new_instance, i_key_schedule[1408]
//                                  : sideband in; o_* passthrough out
// Optional: define AES_GCM_STAGE_STATS_EN to add o_beat_count / o_stall_count.
module aes_gcm_round_stage
  import aes_pkg::*;
#(
  parameter int unsigned NUM_CB_LANES = 1,
  parameter int unsigned CB_ROUND     = 5,
  parameter int unsigned J0_ROUND     = 5,
  parameter int unsigned H_ROUND      = 7
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                i_valid,
  output logic                                o_ready,
  input  logic [AES_BLOCK_W-1:0]              i_h,
  input  logic [AES_BLOCK_W-1:0]              i_encrypted_j0,
  input  logic [AES_BLOCK_W*NUM_CB_LANES-1:0] i_encrypted_cb,
  input  logic [AES_BLOCK_W*NUM_CB_LANES-1:0] i_plain_text,
  input  logic [AES_BLOCK_W-1:0]              i_aad,
  input  logic [AES_BLOCK_W-1:0]              i_instance_size,
  input  logic                                i_new_instance,
  input  logic [AES_KS_W-1:0]                 i_key_schedule,
  output logic                                o_valid,
  input  logic                                i_ready,
  output logic [AES_BLOCK_W-1:0]              o_h,
  output logic [AES_BLOCK_W-1:0]              o_encrypted_j0,
  output logic [AES_BLOCK_W*NUM_CB_LANES-1:0] o_encrypted_cb,
  output logic [AES_BLOCK_W*NUM_CB_LANES-1:0] o_plain_text,
  output logic [AES_BLOCK_W-1:0]              o_aad,
  output logic [AES_BLOCK_W-1:0]              o_instance_size,
  output logic                                o_new_instance,
  output logic [AES_KS_W-1:0]                 o_key_schedule
`ifdef AES_GCM_STAGE_STATS_EN
  ,
  output logic [31:0]                         o_beat_count,
  output logic [31:0]                         o_stall_count
`endif
);

  localparam int unsigned CB_W = AES_BLOCK_W * NUM_CB_LANES;

  if (NUM_CB_LANES < 1 || NUM_CB_LANES > 8) begin : g_bad_lanes
    $error("aes_gcm_round_stage: NUM_CB_LANES must be 1..8");
  end
  if (CB_ROUND > AES_NUM_ROUNDS) begin : g_bad_cb_round
    $error("aes_gcm_round_stage: CB_ROUND must be 0..10");
  end
  if (J0_ROUND > AES_NUM_ROUNDS) begin : g_bad_j0_round
    $error("aes_gcm_round_stage: J0_ROUND must be 0..10");
  end
  if (H_ROUND > AES_NUM_ROUNDS) begin : g_bad_h_round
    $error("aes_gcm_round_stage: H_ROUND must be 0..10");
  end

  typedef struct packed {
    logic [AES_BLOCK_W-1:0] h;
    logic [AES_BLOCK_W-1:0] j0;
    logic [CB_W-1:0]        cb;
    logic [CB_W-1:0]        pt;
    aes_sideband_t          sb;
    logic [AES_KS_W-1:0]    ks;
  } beat_t;

  beat_t beat_in, beat_m;

  always_comb begin
    beat_in                  = '0;
    beat_in.h                = i_h;
    beat_in.j0               = i_encrypted_j0;
    beat_in.cb               = i_encrypted_cb;
    beat_in.pt               = i_plain_text;
    beat_in.sb.aad           = i_aad;
    beat_in.sb.instance_size = i_instance_size;
    beat_in.sb.new_instance  = i_new_instance;
    beat_in.ks               = i_key_schedule;
  end

  // Raw inputs are buffered and the round is computed from M, so a stalled
  // beat keeps its own key schedule and the rounds sit after the flops.
  aes_stage_skid_buf #(
    .WIDTH ($bits(beat_t))
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (beat_in),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (beat_m)
  );

  assign o_h            = fn_aes_encrypt_stage(beat_m.h,  beat_m.ks, H_ROUND);
  assign o_encrypted_j0 = fn_aes_encrypt_stage(beat_m.j0, beat_m.ks, J0_ROUND);

  for (genvar k = 0; k < NUM_CB_LANES; k++) begin : g_cb_lane
    assign o_encrypted_cb[AES_BLOCK_W*k +: AES_BLOCK_W] =
      fn_aes_encrypt_stage(beat_m.cb[AES_BLOCK_W*k +: AES_BLOCK_W], beat_m.ks, CB_ROUND);
  end

  assign o_plain_text    = beat_m.pt;
  assign o_aad           = beat_m.sb.aad;
  assign o_instance_size = beat_m.sb.instance_size;
  assign o_new_instance  = beat_m.sb.new_instance;
  assign o_key_schedule  = beat_m.ks;

`ifdef AES_GCM_STAGE_STATS_EN
  logic [31:0] beat_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (o_valid && i_ready)  beat_cnt_q  <= beat_cnt_q + 32'd1;
      if (o_valid && !i_ready) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign o_beat_count  = beat_cnt_q;
  assign o_stall_count = stall_cnt_q;
`endif

endmodule
